// File: rtl/axi4_slave_write_ctrl.sv
// AXI4 slave write sequencer: accepts one AW burst at a time, steps beat addresses
// for FIXED/INCR, masks strobes to the active lanes, drives a memory write port, returns B.
//
//  state   | meaning
//  IDLE    | awready high, waiting for a write address
//  DATA    | wready high, one memory write per W beat until beat awlen
//  RESP    | bvalid high, holding bid/bresp until bready
module axi4_slave_write_ctrl #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 8,
    parameter int STROBE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [ID_WIDTH-1:0]      awid,
    input  logic [ADDRESS_WIDTH-1:0] awaddr,
    input  logic [7:0]               awlen,
    input  logic [2:0]               awsize,
    input  logic [1:0]               awburst,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [STROBE_WIDTH-1:0]  wstrb,
    input  logic                     wlast,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [ID_WIDTH-1:0]      bid,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [STROBE_WIDTH-1:0]  mem_be
);

    localparam int LOG2_STRB = $clog2(STROBE_WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]               state_q, state_d;
    logic                     awready_q, awready_d;
    logic                     wready_q, wready_d;
    logic                     bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]      id_q, id_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]               len_q, len_d;
    logic [2:0]               size_q, size_d;
    logic [1:0]               burst_q, burst_d;
    logic [7:0]               beat_q, beat_d;
    logic                     err_ill_q, err_ill_d;
    logic                     err_last_q, err_last_d;
    logic [1:0]               bresp_q, bresp_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [STROBE_WIDTH-1:0]  mem_be_q, mem_be_d;

    logic                     aw_hs, w_hs, b_hs;
    logic                     aw_illegal;
    logic                     is_last;
    logic [2:0]               size_eff;
    logic [ADDRESS_WIDTH-1:0] step;
    logic [ADDRESS_WIDTH-1:0] addr_next;
    logic [STROBE_WIDTH-1:0]  lane_mask;

    assign aw_hs      = awvalid & awready_q;
    assign w_hs       = wvalid & wready_q;
    assign b_hs       = bvalid_q & bready;
    assign aw_illegal = awburst[1] | (awsize > 3'(LOG2_STRB));
    assign is_last    = (beat_q == len_q);

    // An illegal size never writes, but clamping keeps the lane/step math in range.
    assign size_eff  = (size_q > 3'(LOG2_STRB)) ? 3'(LOG2_STRB) : size_q;
    assign step      = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1} << size_eff;
    assign addr_next = (addr_q & ~(step - 1'b1)) + step;

    always_comb begin
        int nbytes;
        int off;
        lane_mask = '0;
        nbytes    = 1 << size_eff;
        off       = int'(addr_q[LOG2_STRB-1:0]) & ~(nbytes - 1);
        for (int i = 0; i < STROBE_WIDTH; i++) begin
            lane_mask[i] = (i >= off) && (i < off + nbytes);
        end
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        err_ill_d   = err_ill_q;
        err_last_d  = err_last_q;
        bresp_d     = bresp_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;

        case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    id_d       = awid;
                    addr_d     = awaddr;
                    len_d      = awlen;
                    size_d     = awsize;
                    burst_d    = awburst;
                    beat_d     = '0;
                    err_ill_d  = aw_illegal;
                    err_last_d = 1'b0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    mem_we_d    = ~err_ill_q;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata;
                    mem_be_d    = wstrb & lane_mask;
                    // A wlast mismatch only poisons the response; the beat still lands.
                    if (wlast != is_last) begin
                        err_last_d = 1'b1;
                    end
                    if (burst_q == BURST_INCR) begin
                        addr_d = addr_next;
                    end
                    beat_d = beat_q + 8'd1;
                    if (is_last) begin
                        state_d = ST_RESP;
                        bresp_d = (err_ill_q | err_last_d) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            ST_RESP: begin
                if (b_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        awready_d = (state_d == ST_IDLE);
        wready_d  = (state_d == ST_DATA);
        bvalid_d  = (state_d == ST_RESP);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            beat_q      <= '0;
            err_ill_q   <= 1'b0;
            err_last_q  <= 1'b0;
            bresp_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            err_ill_q   <= err_ill_d;
            err_last_q  <= err_last_d;
            bresp_q     <= bresp_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign awready   = awready_q;
    assign wready    = wready_q;
    assign bvalid    = bvalid_q;
    assign bid       = id_q;
    assign bresp     = bresp_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_axi4_slave_write_ctrl.sv
// Directed testbench for axi4_slave_write_ctrl: scenario tasks with hand-computed expectations.
module tb_axi4_slave_write_ctrl;

    logic        aclk;
    logic        aresetn;
    logic [7:0]  awid;
    logic [15:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] q_addr[$];
    logic [3:0]  q_be[$];
    logic [31:0] q_data[$];

    axi4_slave_write_ctrl dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bid       (bid),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (mem_we) begin
            q_addr.push_back(mem_addr);
            q_be.push_back(mem_be);
            q_data.push_back(mem_wdata);
        end
    end

    task automatic clear_log();
        q_addr.delete();
        q_be.delete();
        q_data.delete();
    endtask

    task automatic do_aw(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (!awready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        n_checks++;
        if (!awready) begin
            $display("FAIL aw_timeout: awready=%0b required 1", awready);
            n_errors++;
        end
        @(negedge aclk);
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        while (!wready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        n_checks++;
        if (!wready) begin
            $display("FAIL w_timeout: wready=%0b required 1", wready);
            n_errors++;
        end
        @(negedge aclk);
        wvalid = 1'b0;
    endtask

    task automatic wait_b(input logic [7:0] exp_id, input logic [1:0] exp_resp);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        n_checks++;
        if (!bvalid) begin
            $display("FAIL b_timeout: bvalid=%0b required 1", bvalid);
            n_errors++;
        end
        n_checks++;
        if (bid !== exp_id) begin
            $display("FAIL bid: got %h required %h", bid, exp_id);
            n_errors++;
        end
        n_checks++;
        if (bresp !== exp_resp) begin
            $display("FAIL bresp: got %b required %b", bresp, exp_resp);
            n_errors++;
        end
        @(negedge aclk);
        bready = 1'b0;
        n_checks++;
        if (awready !== 1'b1 || bvalid !== 1'b0) begin
            $display("FAIL post_b: awready=%b bvalid=%b required 1/0", awready, bvalid);
            n_errors++;
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        #1;
        n_checks++;
        if ({awready, wready, bvalid, mem_we} !== 4'b0000 || bid !== 8'h00 || bresp !== 2'b00
            || mem_addr !== 16'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin
            $display("FAIL reset_outputs: aw=%b w=%b b=%b we=%b bid=%h bresp=%b addr=%h data=%h be=%b required all 0",
                     awready, wready, bvalid, mem_we, bid, bresp, mem_addr, mem_wdata, mem_be);
            n_errors++;
        end
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        #1;
        n_checks++;
        if (awready !== 1'b0) begin
            $display("FAIL awready_before_edge: got %b required 0", awready);
            n_errors++;
        end
        @(negedge aclk);
        n_checks++;
        if (awready !== 1'b1) begin
            $display("FAIL awready_after_edge: got %b required 1", awready);
            n_errors++;
        end
    endtask

    task automatic test_single();
        clear_log();
        do_aw(8'h5A, 16'h0010, 8'd0, 3'd2, 2'b01);
        n_checks++;
        if (wready !== 1'b1 || awready !== 1'b0) begin
            $display("FAIL single_aw_timing: wready=%b awready=%b required 1/0", wready, awready);
            n_errors++;
        end
        w_beat(32'hDEADBEEF, 4'b1111, 1'b1);
        n_checks++;
        if (mem_we !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b1) begin
            $display("FAIL single_w_timing: mem_we=%b wready=%b bvalid=%b required 1/0/1", mem_we, wready, bvalid);
            n_errors++;
        end
        @(negedge aclk);
        n_checks++;
        if (mem_we !== 1'b0) begin
            $display("FAIL single_we_pulse: mem_we=%b required 0", mem_we);
            n_errors++;
        end
        wait_b(8'h5A, 2'b00);
        n_checks++;
        if (q_addr.size() != 1 || q_addr[0] !== 16'h0010 || q_be[0] !== 4'b1111 || q_data[0] !== 32'hDEADBEEF) begin
            $display("FAIL single_write: writes=%0d addr=%h be=%b data=%h required 1/0010/1111/deadbeef",
                     q_addr.size(), q_addr.size() > 0 ? q_addr[0] : 16'hx, q_be.size() > 0 ? q_be[0] : 4'hx,
                     q_data.size() > 0 ? q_data[0] : 32'hx);
            n_errors++;
        end
    endtask

    task automatic test_incr_byte();
        logic [15:0] ea[4] = '{16'h0003, 16'h0004, 16'h0005, 16'h0006};
        logic [3:0]  eb[4] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
        clear_log();
        do_aw(8'h11, 16'h0003, 8'd3, 3'd0, 2'b01);
        for (int i = 0; i < 4; i++) w_beat(32'h1000_0000 + i, 4'b1111, i == 3);
        wait_b(8'h11, 2'b00);
        n_checks++;
        if (q_addr.size() != 4) begin
            $display("FAIL incr_count: got %0d required 4", q_addr.size());
            n_errors++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (q_addr[i] !== ea[i] || q_be[i] !== eb[i] || q_data[i] !== 32'h1000_0000 + i) begin
                    $display("FAIL incr_beat%0d: addr=%h be=%b data=%h required %h/%b/%h",
                             i, q_addr[i], q_be[i], q_data[i], ea[i], eb[i], 32'h1000_0000 + i);
                    n_errors++;
                end
            end
        end
    endtask

    task automatic test_fixed();
        clear_log();
        do_aw(8'h22, 16'h0102, 8'd2, 3'd1, 2'b00);
        for (int i = 0; i < 3; i++) w_beat(32'hA0A0_0000 + i, 4'b1111, i == 2);
        wait_b(8'h22, 2'b00);
        n_checks++;
        if (q_addr.size() != 3) begin
            $display("FAIL fixed_count: got %0d required 3", q_addr.size());
            n_errors++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (q_addr[i] !== 16'h0102 || q_be[i] !== 4'b1100) begin
                    $display("FAIL fixed_beat%0d: addr=%h be=%b required 0102/1100", i, q_addr[i], q_be[i]);
                    n_errors++;
                end
            end
        end
    endtask

    task automatic test_wrap();
        clear_log();
        do_aw(8'h33, 16'hFFFC, 8'd1, 3'd2, 2'b01);
        w_beat(32'h1111_1111, 4'b1111, 1'b0);
        w_beat(32'h2222_2222, 4'b1111, 1'b1);
        wait_b(8'h33, 2'b00);
        n_checks++;
        if (q_addr.size() != 2 || q_addr[0] !== 16'hFFFC || q_addr[1] !== 16'h0000) begin
            $display("FAIL wrap_addr: writes=%0d first=%h second=%h required 2/fffc/0000", q_addr.size(),
                     q_addr.size() > 0 ? q_addr[0] : 16'hx, q_addr.size() > 1 ? q_addr[1] : 16'hx);
            n_errors++;
        end
    endtask

    task automatic test_illegal();
        clear_log();
        do_aw(8'h44, 16'h0040, 8'd1, 3'd2, 2'b10);
        w_beat(32'h3333_3333, 4'b1111, 1'b0);
        w_beat(32'h4444_4444, 4'b1111, 1'b1);
        wait_b(8'h44, 2'b10);
        n_checks++;
        if (q_addr.size() != 0) begin
            $display("FAIL illegal_no_write: writes=%0d required 0", q_addr.size());
            n_errors++;
        end
    endtask

    task automatic test_wlast_err();
        clear_log();
        do_aw(8'h55, 16'h0080, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) w_beat(32'h5555_0000 + i, 4'b1111, i == 1);
        wait_b(8'h55, 2'b10);
        n_checks++;
        if (q_addr.size() != 4 || q_addr[3] !== 16'h008C) begin
            $display("FAIL wlast_writes: writes=%0d last_addr=%h required 4/008c", q_addr.size(),
                     q_addr.size() > 3 ? q_addr[3] : 16'hx);
            n_errors++;
        end
    endtask

    task automatic test_back_to_back_bstall();
        int n = 0;
        clear_log();
        do_aw(8'h66, 16'h0200, 8'd0, 3'd2, 2'b01);
        w_beat(32'h6666_6666, 4'b0011, 1'b1);
        while (!bvalid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bvalid !== 1'b1 || bid !== 8'h66 || bresp !== 2'b00 || awready !== 1'b0) begin
                $display("FAIL bstall_cycle%0d: bvalid=%b bid=%h bresp=%b awready=%b required 1/66/00/0",
                         i, bvalid, bid, bresp, awready);
                n_errors++;
            end
            @(negedge aclk);
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        n_checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            $display("FAIL bstall_release: bvalid=%b awready=%b required 0/1", bvalid, awready);
            n_errors++;
        end
        n_checks++;
        if (q_be.size() != 1 || q_be[0] !== 4'b0011) begin
            $display("FAIL bstall_write: writes=%0d be=%b required 1/0011", q_be.size(),
                     q_be.size() > 0 ? q_be[0] : 4'hx);
            n_errors++;
        end
    endtask

    task automatic test_reset_mid();
        int seen_b = 0;
        clear_log();
        do_aw(8'h77, 16'h0300, 8'd3, 3'd2, 2'b01);
        w_beat(32'h7777_0000, 4'b1111, 1'b0);
        w_beat(32'h7777_0001, 4'b1111, 1'b0);
        aresetn = 1'b0;
        #1;
        n_checks++;
        if ({awready, wready, bvalid, mem_we} !== 4'b0000 || bid !== 8'h00 || bresp !== 2'b00
            || mem_addr !== 16'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin
            $display("FAIL midreset_outputs: aw=%b w=%b b=%b we=%b addr=%h data=%h be=%b required all 0",
                     awready, wready, bvalid, mem_we, mem_addr, mem_wdata, mem_be);
            n_errors++;
        end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        clear_log();
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            if (bvalid) seen_b++;
        end
        n_checks++;
        if (seen_b != 0 || q_addr.size() != 0 || wready !== 1'b0) begin
            $display("FAIL midreset_quiet: bvalid_cycles=%0d writes=%0d wready=%b required 0/0/0",
                     seen_b, q_addr.size(), wready);
            n_errors++;
        end
        do_aw(8'h88, 16'h0020, 8'd0, 3'd2, 2'b01);
        w_beat(32'hCAFE_F00D, 4'b1111, 1'b1);
        wait_b(8'h88, 2'b00);
        n_checks++;
        if (q_addr.size() != 1 || q_addr[0] !== 16'h0020 || q_data[0] !== 32'hCAFE_F00D) begin
            $display("FAIL midreset_recover: writes=%0d addr=%h required 1/0020", q_addr.size(),
                     q_addr.size() > 0 ? q_addr[0] : 16'hx);
            n_errors++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_incr_byte();
        test_fixed();
        test_wrap();
        test_illegal();
        test_wlast_err();
        test_back_to_back_bstall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
